// File: rtl/mem_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl_if
//
// Bundles every bus-level signal of the memory-bus controller: the CPU
// MEM-stage request/response pair, the off-chip SRAM port and the UART port.
//
//   slave  modport : the controller's view (takes CPU requests, drives the
//                    SRAM and UART strobes, returns read data).
//   master modport : the surrounding system's view (CPU, SRAM and UART
//                    models or real peripherals).
//
// Signal summary (direction as seen by the controller):
//   mem_enable_i     in   access request
//   mem_rw_i         in   1 = write, 0 = read
//   mem_addr_i       in   access address
//   mem_wdata_i      in   write data
//   mem_rdata_o      out  read data, valid while mem_ready_o
//   mem_ready_o      out  one-cycle completion pulse
//   stall_o          out  pipeline hold
//   ram_en_o         out  SRAM chip enable
//   ram_we_o         out  SRAM write strobe
//   ram_addr_o       out  SRAM address
//   ram_wdata_o      out  SRAM write data
//   ram_rdata_i      in   SRAM read data
//   uart_wr_o        out  one-cycle transmit strobe
//   uart_rd_o        out  one-cycle receive-pop strobe
//   uart_wdata_o     out  transmit data
//   uart_rdata_i     in   received data
//   uart_tx_ready_i  in   transmitter idle
//   uart_rx_valid_i  in   received byte pending
// ---------------------------------------------------------------------------
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  // CPU side
  logic              mem_enable_i;
  logic              mem_rw_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_ready_o;
  logic              stall_o;

  // SRAM side
  logic              ram_en_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;

  // UART side
  logic              uart_wr_o;
  logic              uart_rd_o;
  logic [DATA_W-1:0] uart_wdata_o;
  logic [DATA_W-1:0] uart_rdata_i;
  logic              uart_tx_ready_i;
  logic              uart_rx_valid_i;

  modport slave (
    input  mem_enable_i, mem_rw_i, mem_addr_i, mem_wdata_i,
    output mem_rdata_o, mem_ready_o, stall_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i,
    output uart_wr_o, uart_rd_o, uart_wdata_o,
    input  uart_rdata_i, uart_tx_ready_i, uart_rx_valid_i
  );

  modport master (
    output mem_enable_i, mem_rw_i, mem_addr_i, mem_wdata_i,
    input  mem_rdata_o, mem_ready_o, stall_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i,
    input  uart_wr_o, uart_rd_o, uart_wdata_o,
    output uart_rdata_i, uart_tx_ready_i, uart_rx_valid_i
  );

endinterface

// File: rtl/mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl
//
// Multi-cycle memory-bus controller between the CPU MEM stage and the
// off-chip SRAM / UART. A request seen in IDLE is latched and decoded by
// address:
//   - SER_STAT_ADDR        : answered in one cycle (status read returns
//                            {rx_valid, tx_ready} in bits 1:0).
//   - SER_DATA_ADDR read   : one receive-pop strobe, then done.
//   - SER_DATA_ADDR write  : wait for an idle transmitter, one transmit
//                            strobe, then done.
//   - anything else        : SRAM access held for RAM_WAIT cycles.
// The pipeline is stalled until the DONE cycle, where mem_ready_o pulses
// and mem_rdata_o carries the result (0 for writes).
//
// Ports:
//   clk  : system clock, all state on the rising edge
//   rst  : asynchronous, active-low reset
//   bus  : mem_bus_ctrl_if.slave, CPU / SRAM / UART signals
//
// Parameters:
//   ADDR_W, DATA_W       : bus widths (must match the interface instance)
//   RAM_WAIT             : SRAM access length in cycles (>= 1)
//   SER_DATA_ADDR        : UART data register address
//   SER_STAT_ADDR        : UART status register address
// ---------------------------------------------------------------------------
module mem_bus_ctrl #(
  parameter int              ADDR_W        = 16,
  parameter int              DATA_W        = 16,
  parameter int              RAM_WAIT      = 2,
  parameter logic [ADDR_W-1:0] SER_DATA_ADDR = 16'hBF00,
  parameter logic [ADDR_W-1:0] SER_STAT_ADDR = 16'hBF01
) (
  input  logic          clk,
  input  logic          rst,
  mem_bus_ctrl_if.slave bus
);

  // Counter only has to hold RAM_WAIT-1.
  localparam int CNT_W = (RAM_WAIT > 1) ? $clog2(RAM_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAM,
    S_TX_WAIT,
    S_SER,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  // Request captured in IDLE; the CPU-side inputs are ignored afterwards.
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rw_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q;

  // Address decode of the live request, used only while in IDLE, where it
  // is identical to what is being latched.
  logic              req_is_data;
  logic              req_is_stat;

  assign req_is_data = (bus.mem_addr_i == SER_DATA_ADDR);
  assign req_is_stat = (bus.mem_addr_i == SER_STAT_ADDR);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and Moore outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_nxt        = state;
    bus.mem_ready_o  = 1'b0;
    bus.mem_rdata_o  = '0;
    bus.ram_en_o     = 1'b0;
    bus.ram_we_o     = 1'b0;
    bus.ram_addr_o   = '0;
    bus.ram_wdata_o  = '0;
    bus.uart_wr_o    = 1'b0;
    bus.uart_rd_o    = 1'b0;
    bus.uart_wdata_o = '0;

    unique case (state)
      S_IDLE: begin
        if (bus.mem_enable_i) begin
          if (req_is_stat) begin
            state_nxt = S_DONE;
          end else if (req_is_data) begin
            state_nxt = bus.mem_rw_i ? S_TX_WAIT : S_SER;
          end else begin
            state_nxt = S_RAM;
          end
        end
      end

      S_RAM: begin
        // SRAM outputs come only from latched registers, so they stay
        // stable for the whole access.
        bus.ram_en_o    = 1'b1;
        bus.ram_we_o    = rw_q;
        bus.ram_addr_o  = addr_q;
        bus.ram_wdata_o = wdata_q;
        if (cnt_q == '0) begin
          state_nxt = S_DONE;
        end
      end

      S_TX_WAIT: begin
        // Unbounded wait: the transmitter is assumed to drain eventually.
        if (bus.uart_tx_ready_i) begin
          state_nxt = S_SER;
        end
      end

      S_SER: begin
        // SER lasts exactly one cycle, so each strobe is a single pulse.
        bus.uart_wr_o = rw_q;
        bus.uart_rd_o = !rw_q;
        if (rw_q) begin
          bus.uart_wdata_o = wdata_q;
        end
        state_nxt = S_DONE;
      end

      S_DONE: begin
        bus.mem_ready_o = 1'b1;
        bus.mem_rdata_o = rdata_q;
        state_nxt       = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Hold the pipeline for as long as a request is outstanding; DONE is the
  // cycle in which the result is handed over.
  assign bus.stall_o = bus.mem_enable_i && (state != S_DONE);

  // -------------------------------------------------------------------------
  // Request latch, wait counter and read-data register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.mem_enable_i) begin
            addr_q  <= bus.mem_addr_i;
            wdata_q <= bus.mem_wdata_i;
            rw_q    <= bus.mem_rw_i;
            cnt_q   <= CNT_W'(RAM_WAIT - 1);
            // Writes return 0; a status read is answered right away from
            // the live UART flags.
            if (req_is_stat && !bus.mem_rw_i) begin
              rdata_q <= DATA_W'({bus.uart_rx_valid_i, bus.uart_tx_ready_i});
            end else begin
              rdata_q <= '0;
            end
          end
        end

        S_RAM: begin
          if (cnt_q == '0) begin
            if (!rw_q) begin
              rdata_q <= bus.ram_rdata_i;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_SER: begin
          // A pop with nothing pending still returns whatever the UART
          // presents; software is expected to poll status first.
          if (!rw_q) begin
            rdata_q <= bus.uart_rdata_i;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_ctrl
//
// Directed bench for mem_bus_ctrl. Two instances share the clock:
//   dut2 : RAM_WAIT = 2, used for RAM, UART and back-to-back accesses.
//   dut3 : RAM_WAIT = 3, used for the reset-during-RAM-write case.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. "Cycle k" counts rising edges from the request cycle.
// ---------------------------------------------------------------------------
module tb_mem_bus_ctrl;

  logic clk;
  logic rst;
  logic rst3;

  int n_checks;
  int n_pass;

  int rdy2_cnt;
  int rdy3_cnt;
  int wr2_cnt;
  int rd2_cnt;

  int snap;

  mem_bus_ctrl_if #(.ADDR_W(16), .DATA_W(16)) b2 ();
  mem_bus_ctrl_if #(.ADDR_W(16), .DATA_W(16)) b3 ();

  mem_bus_ctrl #(
    .ADDR_W(16), .DATA_W(16), .RAM_WAIT(2),
    .SER_DATA_ADDR(16'hBF00), .SER_STAT_ADDR(16'hBF01)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(b2)
  );

  mem_bus_ctrl #(
    .ADDR_W(16), .DATA_W(16), .RAM_WAIT(3),
    .SER_DATA_ADDR(16'hBF00), .SER_STAT_ADDR(16'hBF01)
  ) dut3 (
    .clk(clk),
    .rst(rst3),
    .bus(b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters for the single-strobe / no-ready checks.
  always @(posedge clk) begin
    if (b2.mem_ready_o) rdy2_cnt <= rdy2_cnt + 1;
    if (b3.mem_ready_o) rdy3_cnt <= rdy3_cnt + 1;
    if (b2.uart_wr_o)   wr2_cnt  <= wr2_cnt + 1;
    if (b2.uart_rd_o)   rd2_cnt  <= rd2_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rdy2_cnt = 0;
    rdy3_cnt = 0;
    wr2_cnt  = 0;
    rd2_cnt  = 0;

    rst  = 1'b0;
    rst3 = 1'b0;
    b2.mem_enable_i = 0; b2.mem_rw_i = 0; b2.mem_addr_i = '0; b2.mem_wdata_i = '0;
    b2.ram_rdata_i = '0; b2.uart_rdata_i = '0; b2.uart_tx_ready_i = 0; b2.uart_rx_valid_i = 0;
    b3.mem_enable_i = 0; b3.mem_rw_i = 0; b3.mem_addr_i = '0; b3.mem_wdata_i = '0;
    b3.ram_rdata_i = '0; b3.uart_rdata_i = '0; b3.uart_tx_ready_i = 0; b3.uart_rx_valid_i = 0;

    // ---------------- reset state ----------------
    adv(); adv(); smp();
    check("rst_ready",   b2.mem_ready_o, 0);
    check("rst_rdata",   b2.mem_rdata_o, 0);
    check("rst_stall",   b2.stall_o,     0);
    check("rst_ram_en",  b2.ram_en_o,    0);
    check("rst_ram_adr", b2.ram_addr_o,  0);
    check("rst_uart",    {b2.uart_wr_o, b2.uart_rd_o}, 0);
    b2.mem_enable_i = 1;
    #1;
    check("rst_stall_en", b2.stall_o, 1);
    b2.mem_enable_i = 0;
    #1;
    rst  = 1'b1;
    rst3 = 1'b1;
    adv();

    // ---------------- RAM read 0x4000 -> 0x1234 ----------------
    b2.mem_enable_i = 1; b2.mem_rw_i = 0; b2.mem_addr_i = 16'h4000;
    b2.ram_rdata_i = 16'h1234;
    smp();  // cycle 0
    check("rr_c0_stall",  b2.stall_o,     1);
    check("rr_c0_ram_en", b2.ram_en_o,    0);
    check("rr_c0_ready",  b2.mem_ready_o, 0);
    adv(); smp();  // cycle 1
    check("rr_c1_ram_en", b2.ram_en_o,   1);
    check("rr_c1_ram_we", b2.ram_we_o,   0);
    check("rr_c1_addr",   b2.ram_addr_o, 16'h4000);
    check("rr_c1_stall",  b2.stall_o,    1);
    adv(); smp();  // cycle 2
    check("rr_c2_ram_en", b2.ram_en_o,    1);
    check("rr_c2_addr",   b2.ram_addr_o,  16'h4000);
    check("rr_c2_stall",  b2.stall_o,     1);
    check("rr_c2_ready",  b2.mem_ready_o, 0);
    adv(); smp();  // cycle 3
    check("rr_c3_ready",  b2.mem_ready_o, 1);
    check("rr_c3_rdata",  b2.mem_rdata_o, 16'h1234);
    check("rr_c3_stall",  b2.stall_o,     0);
    check("rr_c3_ram_en", b2.ram_en_o,    0);
    b2.mem_enable_i = 0;
    adv(); smp();  // cycle 4
    check("rr_c4_ready",  b2.mem_ready_o, 0);
    check("rr_c4_rdata",  b2.mem_rdata_o, 0);

    // ---------------- status read rx=1 tx=0 ----------------
    adv();
    b2.mem_enable_i = 1; b2.mem_rw_i = 0; b2.mem_addr_i = 16'hBF01;
    b2.uart_rx_valid_i = 1; b2.uart_tx_ready_i = 0;
    smp();
    check("st1_c0_stall", b2.stall_o, 1);
    check("st1_c0_ready", b2.mem_ready_o, 0);
    adv(); smp();
    check("st1_c1_ready", b2.mem_ready_o, 1);
    check("st1_c1_rdata", b2.mem_rdata_o, 16'h0002);
    check("st1_c1_stall", b2.stall_o, 0);
    b2.mem_enable_i = 0;
    adv();

    // ---------------- status read rx=0 tx=1 ----------------
    b2.mem_enable_i = 1; b2.mem_addr_i = 16'hBF01;
    b2.uart_rx_valid_i = 0; b2.uart_tx_ready_i = 1;
    adv(); smp();
    check("st2_c1_ready", b2.mem_ready_o, 1);
    check("st2_c1_rdata", b2.mem_rdata_o, 16'h0001);
    b2.mem_enable_i = 0;
    adv();

    // ---------------- status write: no side effect, data 0 ----------------
    snap = wr2_cnt + rd2_cnt;
    b2.mem_enable_i = 1; b2.mem_rw_i = 1; b2.mem_addr_i = 16'hBF01; b2.mem_wdata_i = 16'hFFFF;
    adv(); smp();
    check("sw_c1_ready",  b2.mem_ready_o, 1);
    check("sw_c1_rdata",  b2.mem_rdata_o, 0);
    b2.mem_enable_i = 0;
    adv();
    check("sw_no_strobe", wr2_cnt + rd2_cnt, snap);

    // ---------------- UART data read 0x005A, then back-to-back RAM write ----------------
    snap = rd2_cnt;
    b2.mem_enable_i = 1; b2.mem_rw_i = 0; b2.mem_addr_i = 16'hBF00;
    b2.uart_rdata_i = 16'h005A; b2.uart_rx_valid_i = 1;
    smp();  // cycle 0
    check("dr_c0_rd", b2.uart_rd_o, 0);
    adv(); smp();  // cycle 1
    check("dr_c1_rd",    b2.uart_rd_o,   1);
    check("dr_c1_stall", b2.stall_o,     1);
    check("dr_c1_ready", b2.mem_ready_o, 0);
    adv(); smp();  // cycle 2
    check("dr_c2_ready", b2.mem_ready_o, 1);
    check("dr_c2_rdata", b2.mem_rdata_o, 16'h005A);
    check("dr_c2_rd",    b2.uart_rd_o,   0);
    check("dr_rd_once",  rd2_cnt - snap, 1);
    b2.mem_rw_i = 1; b2.mem_addr_i = 16'h0123; b2.mem_wdata_i = 16'hBEEF;
    adv(); smp();  // cycle 3: IDLE, accepts the write
    check("bb_c3_stall",  b2.stall_o,  1);
    check("bb_c3_ram_en", b2.ram_en_o, 0);
    adv(); smp();  // cycle 4
    check("bb_c4_ram_en", b2.ram_en_o,    1);
    check("bb_c4_ram_we", b2.ram_we_o,    1);
    check("bb_c4_addr",   b2.ram_addr_o,  16'h0123);
    check("bb_c4_wdata",  b2.ram_wdata_o, 16'hBEEF);
    adv(); smp();  // cycle 5
    check("bb_c5_ram_we", b2.ram_we_o, 1);
    adv(); smp();  // cycle 6
    check("bb_c6_ready",  b2.mem_ready_o, 1);
    check("bb_c6_rdata",  b2.mem_rdata_o, 0);
    check("bb_c6_ram_en", b2.ram_en_o,    0);
    check("bb_c6_wdata",  b2.ram_wdata_o, 0);
    b2.mem_enable_i = 0;
    adv();

    // ---------------- UART write 0x0041, tx busy for 4 cycles ----------------
    snap = wr2_cnt;
    b2.mem_enable_i = 1; b2.mem_rw_i = 1; b2.mem_addr_i = 16'hBF00; b2.mem_wdata_i = 16'h0041;
    b2.uart_tx_ready_i = 0;
    for (int c = 1; c <= 3; c++) begin
      adv(); smp();  // cycles 1..3 in TX_WAIT
      check("uw_wait_wr",    b2.uart_wr_o,   0);
      check("uw_wait_stall", b2.stall_o,     1);
    end
    adv();  // cycle 4: last TX_WAIT cycle, transmitter becomes idle
    b2.uart_tx_ready_i = 1;
    smp();
    check("uw_c4_wr", b2.uart_wr_o, 0);
    adv(); smp();  // cycle 5: SER
    check("uw_c5_wr",    b2.uart_wr_o,    1);
    check("uw_c5_wdata", b2.uart_wdata_o, 16'h0041);
    check("uw_c5_ready", b2.mem_ready_o,  0);
    adv(); smp();  // cycle 6: DONE
    check("uw_c6_ready", b2.mem_ready_o, 1);
    check("uw_c6_rdata", b2.mem_rdata_o, 0);
    check("uw_c6_wr",    b2.uart_wr_o,   0);
    check("uw_wr_once",  wr2_cnt - snap, 1);
    b2.mem_enable_i = 0;
    adv();

    // ---------------- enable dropped mid-access still completes ----------------
    snap = rdy2_cnt;
    b2.mem_enable_i = 1; b2.mem_rw_i = 0; b2.mem_addr_i = 16'h0010; b2.ram_rdata_i = 16'hA5C3;
    adv();
    b2.mem_enable_i = 0;
    smp();  // cycle 1
    check("drop_c1_stall", b2.stall_o, 0);
    adv(); adv(); smp();  // cycle 3
    check("drop_c3_ready", b2.mem_ready_o, 1);
    check("drop_c3_rdata", b2.mem_rdata_o, 16'hA5C3);
    adv();
    check("drop_one_ready", rdy2_cnt - snap, 1);

    // ---------------- dut3: reset during a RAM write ----------------
    b3.mem_enable_i = 1; b3.mem_rw_i = 1; b3.mem_addr_i = 16'h0200; b3.mem_wdata_i = 16'h5555;
    smp();  // cycle 0
    check("r3_c0_stall", b3.stall_o, 1);
    adv(); smp();  // cycle 1
    check("r3_c1_ram_en", b3.ram_en_o, 1);
    check("r3_c1_ram_we", b3.ram_we_o, 1);
    adv(); smp();  // cycle 2
    check("r3_c2_ram_en", b3.ram_en_o, 1);
    snap = rdy3_cnt;
    #1;
    rst3 = 1'b0;
    #1;
    check("r3_rst_ram_en", b3.ram_en_o,    0);
    check("r3_rst_ram_we", b3.ram_we_o,    0);
    check("r3_rst_addr",   b3.ram_addr_o,  0);
    check("r3_rst_ready",  b3.mem_ready_o, 0);
    b3.mem_enable_i = 0;
    adv(); adv(); adv();
    check("r3_no_ready", rdy3_cnt - snap, 0);
    rst3 = 1'b1;
    adv(); smp();
    check("r3_idle_ram_en", b3.ram_en_o,    0);
    check("r3_idle_stall",  b3.stall_o,     0);
    check("r3_idle_ready",  b3.mem_ready_o, 0);
    adv();
    // Fresh RAM read proves the FSM restarted from IDLE: ready at cycle 4.
    b3.mem_enable_i = 1; b3.mem_rw_i = 0; b3.mem_addr_i = 16'h0300; b3.ram_rdata_i = 16'h0F0F;
    adv(); adv(); adv(); smp();  // cycle 3
    check("r3_rd_c3_ready", b3.mem_ready_o, 0);
    check("r3_rd_c3_ram_en", b3.ram_en_o,   1);
    adv(); smp();  // cycle 4
    check("r3_rd_c4_ready", b3.mem_ready_o, 1);
    check("r3_rd_c4_rdata", b3.mem_rdata_o, 16'h0F0F);
    b3.mem_enable_i = 0;
    adv();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
